// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage directly upstream of instruction_memory.
// Owns the program counter and presents a word-aligned byte address to the
// memory. The instruction that comes back combinationally is captured into
// the IF/ID register. Also handles start-up, decode stall, branch redirect
// and the end-of-program halt.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for start; pc held, nothing captured
// RUN   | fetching one word per cycle (branch > stall > normal advance)
// HALT  | past the last valid address; no fetch, only an in-range branch exits
//
// Ports:
//   clk            in   1   clock, all state updates on posedge
//   rst_n          in   1   asynchronous active-low reset
//   start          in   1   level; moves IDLE -> RUN
//   stall          in   1   hold pc and IF/ID register
//   branch_taken   in   1   redirect request from execute
//   branch_target  in   18  byte target of redirect (low two bits ignored)
//   imem_addr      out  18  byte address to instruction memory
//   imem_rd        in   18  instruction read back (combinational)
//   if_instr       out  18  IF/ID instruction
//   if_pc_plus4    out  18  IF/ID pc of captured instruction + 4
//   if_valid       out  1   IF/ID holds a real instruction
//   halted         out  1   high while in HALT
//   fetch_count    out  16  valid instructions captured, saturating
module fetch_stage #(
  parameter logic [17:0] RESET_PC = 18'd0,
  parameter logic [17:0] PC_LIMIT = 18'd400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [17:0] branch_target,
  output logic [17:0] imem_addr,
  input  logic [17:0] imem_rd,
  output logic [17:0] if_instr,
  output logic [17:0] if_pc_plus4,
  output logic        if_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t      state, state_nxt;
  logic [17:0] pc, pc_nxt;
  logic [17:0] instr_nxt, pc_plus4_nxt;
  logic        valid_nxt;
  logic [15:0] count_nxt;

  logic [17:0] tgt;
  logic [18:0] pc_inc_wide;
  logic [17:0] pc_inc;
  logic        tgt_in_range;
  logic        last_word;

  assign tgt          = {branch_target[17:2], 2'b00};
  // Extra bit so a wrap past 2^18 still reads as beyond the limit.
  assign pc_inc_wide  = {1'b0, pc} + 19'd4;
  assign pc_inc       = pc_inc_wide[17:0];
  assign tgt_in_range = (tgt <= PC_LIMIT);
  assign last_word    = (pc_inc_wide > {1'b0, PC_LIMIT});

  assign imem_addr = {pc[17:2], 2'b00};
  assign halted    = (state == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= {RESET_PC[17:2], 2'b00};
      if_instr    <= 18'd0;
      if_pc_plus4 <= 18'd0;
      if_valid    <= 1'b0;
      fetch_count <= 16'd0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      if_instr    <= instr_nxt;
      if_pc_plus4 <= pc_plus4_nxt;
      if_valid    <= valid_nxt;
      fetch_count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    instr_nxt    = if_instr;
    pc_plus4_nxt = if_pc_plus4;
    valid_nxt    = if_valid;
    count_nxt    = fetch_count;

    case (state)
      S_IDLE: begin
        valid_nxt = 1'b0;
        if (start) state_nxt = S_RUN;
      end

      S_RUN: begin
        if (branch_taken) begin
          // Redirect leaves one bubble in IF/ID.
          valid_nxt = 1'b0;
          instr_nxt = 18'd0;
          if (tgt_in_range) pc_nxt = tgt;
          else              state_nxt = S_HALT;
        end else if (!stall) begin
          instr_nxt    = imem_rd;
          pc_plus4_nxt = pc_inc;
          valid_nxt    = 1'b1;
          if (fetch_count != 16'hFFFF) count_nxt = fetch_count + 16'd1;
          // The last word is still captured; pc stays on it while halted.
          if (last_word) state_nxt = S_HALT;
          else           pc_nxt    = pc_inc;
        end
      end

      S_HALT: begin
        valid_nxt = 1'b0;
        if (branch_taken && tgt_in_range) begin
          pc_nxt    = tgt;
          state_nxt = S_RUN;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
